cpu_loader_ctrl_6502: RTL and testbench

//  Sequences program load into the 6502 subsystem RAM over the system-side BRAM port.

---
 rtl/cpu_loader_pkg.sv | 15 +
 rtl/cpu_loader_ctrl_6502.sv | 189 ++++++++++++++++++
 tb/tb_cpu_loader_ctrl_6502.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_loader_pkg.sv
// Shared types for the 6502 program loader: sequencer states and 2-bit error codes.
package cpu_loader_pkg;

  typedef enum logic [2:0] {
    IDLE, HALT, LOAD, VERIFY, CHECK, RELEASE, DONE, ERROR
  } state_t;

  typedef enum logic [1:0] {
    ERR_NONE   = 2'd0,
    ERR_RANGE  = 2'd1,
    ERR_VERIFY = 2'd2,
    ERR_ABORT  = 2'd3
  } err_t;

endpackage

// File: rtl/cpu_loader_ctrl_6502.sv
// Loads a host byte stream into 6502 RAM with the CPU held in reset, optionally
// re-reads it to compare checksums, then releases the CPU.
//
// state   | meaning
// IDLE    | CPU running, waiting for start
// HALT    | CPU held in reset and paused for SettleCycles
// LOAD    | stream bytes written to RAM, one per valid&ready
// VERIFY  | re-read loaded range, 1-cycle read latency plus a drain cycle
// CHECK   | compare re-read checksum with load checksum
// RELEASE | RDY restored, reset held for SettleCycles
// DONE    | one-cycle completion pulse
// ERROR   | load failed or aborted; CPU stays held
module cpu_loader_ctrl_6502
  import cpu_loader_pkg::*;
#(
  parameter int address_width = 16,
  parameter int data_width    = 8,
  parameter int RAM_Size      = 4102,
  parameter int SettleCycles  = 4
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     start_i,
  input  logic [address_width-1:0] start_addr_i,
  input  logic [address_width-1:0] length_i,
  input  logic                     verify_i,
  input  logic                     abort_i,
  input  logic [data_width-1:0]    s_data_i,
  input  logic                     s_valid_i,
  output logic                     s_ready_o,
  output logic [address_width-1:0] ram_addr_o,
  output logic                     ram_we_o,
  output logic [data_width-1:0]    ram_din_o,
  input  logic [data_width-1:0]    ram_dout_i,
  output logic                     cpu_reset_o,
  output logic                     cpu_pause_o,
  output logic                     busy_o,
  output logic                     done_o,
  output logic [1:0]               err_code_o
);

  localparam logic [address_width:0]   RamLimit   = (address_width+1)'(RAM_Size);
  localparam logic [7:0]               SettleLast = 8'(SettleCycles - 1);
  localparam logic [address_width-1:0] One        = address_width'(1);

  state_t                   state_q, state_d;
  err_t                     err_q;
  logic [address_width-1:0] base_q, len_q, ptr_q, rem_q;
  logic [data_width-1:0]    sum_q, vsum_q;
  logic [7:0]               cnt_q;
  logic                     verify_q, rd_pend_q, cpu_reset_q, cpu_pause_q;
  logic                     cpu_reset_d, cpu_pause_d;
  logic                     start_ok, range_bad, xfer, rd_issue, abort_hit;
  logic [address_width:0]   span;

  assign span        = {1'b0, start_addr_i} + {1'b0, length_i};
  assign busy_o      = state_q inside {HALT, LOAD, VERIFY, CHECK, RELEASE};
  assign abort_hit   = abort_i && busy_o;
  assign done_o      = (state_q == DONE);
  assign cpu_reset_o = cpu_reset_q;
  assign cpu_pause_o = cpu_pause_q;
  assign err_code_o  = err_q;

  always_comb begin
    state_d     = state_q;
    s_ready_o   = 1'b0;
    ram_we_o    = 1'b0;
    ram_addr_o  = '0;
    ram_din_o   = '0;
    xfer        = 1'b0;
    rd_issue    = 1'b0;
    start_ok    = 1'b0;
    range_bad   = 1'b0;
    cpu_reset_d = cpu_reset_q;
    cpu_pause_d = cpu_pause_q;

    case (state_q)
      IDLE, ERROR: begin
        if (start_i) begin
          start_ok = 1'b1;
          if (span > RamLimit) begin
            range_bad = 1'b1;
            state_d   = ERROR;
          end else begin
            state_d = HALT;
          end
        end
      end
      HALT:    if (cnt_q == '0) state_d = (len_q == '0) ? RELEASE : LOAD;
      LOAD: begin
        s_ready_o  = 1'b1;
        ram_addr_o = ptr_q;
        ram_din_o  = s_data_i;
        xfer       = s_valid_i;
        ram_we_o   = s_valid_i;
        if (s_valid_i && rem_q == One) state_d = verify_q ? VERIFY : RELEASE;
      end
      VERIFY: begin
        ram_addr_o = ptr_q;
        rd_issue   = (rem_q != '0);
        if (rem_q == '0) state_d = CHECK;
      end
      CHECK:   state_d = (vsum_q == sum_q) ? RELEASE : ERROR;
      RELEASE: if (cnt_q == '0) state_d = DONE;
      default: state_d = IDLE;
    endcase

    // Abort wins over a same-cycle stream transfer: nothing is accepted or written.
    if (abort_hit) begin
      state_d   = ERROR;
      s_ready_o = 1'b0;
      ram_we_o  = 1'b0;
      xfer      = 1'b0;
    end

    case (state_d)
      HALT, LOAD, VERIFY, CHECK: begin
        cpu_reset_d = 1'b1;
        cpu_pause_d = 1'b1;
      end
      RELEASE: begin
        cpu_reset_d = 1'b1;
        cpu_pause_d = 1'b0;
      end
      IDLE, DONE: begin
        cpu_reset_d = 1'b0;
        cpu_pause_d = 1'b0;
      end
      // ERROR from a range reject leaves the CPU as it was
      default: if (busy_o) begin
        cpu_reset_d = 1'b1;
        cpu_pause_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q     <= IDLE;
      err_q       <= ERR_NONE;
      base_q      <= '0;
      len_q       <= '0;
      ptr_q       <= '0;
      rem_q       <= '0;
      sum_q       <= '0;
      vsum_q      <= '0;
      cnt_q       <= '0;
      verify_q    <= 1'b0;
      rd_pend_q   <= 1'b0;
      cpu_reset_q <= 1'b1;
      cpu_pause_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      cpu_reset_q <= cpu_reset_d;
      cpu_pause_q <= cpu_pause_d;
      rd_pend_q   <= rd_issue;
      if (rd_pend_q) vsum_q <= vsum_q + ram_dout_i;
      if (xfer) begin
        ptr_q <= ptr_q + One;
        rem_q <= rem_q - One;
        sum_q <= sum_q + s_data_i;
      end
      if (rd_issue) begin
        ptr_q <= ptr_q + One;
        rem_q <= rem_q - One;
      end
      if ((state_q == HALT || state_q == RELEASE) && cnt_q != '0) cnt_q <= cnt_q - 8'd1;
      if (state_d == RELEASE && state_q != RELEASE) cnt_q <= SettleLast;
      if (state_q == LOAD && state_d == VERIFY) begin
        ptr_q <= base_q;
        rem_q <= len_q;
      end
      if (abort_hit) err_q <= ERR_ABORT;
      else if (state_q == CHECK && state_d == ERROR) err_q <= ERR_VERIFY;
      if (start_ok) begin
        base_q   <= start_addr_i;
        len_q    <= length_i;
        verify_q <= verify_i;
        ptr_q    <= start_addr_i;
        rem_q    <= length_i;
        sum_q    <= '0;
        vsum_q   <= '0;
        cnt_q    <= SettleLast;
        err_q    <= range_bad ? ERR_RANGE : ERR_NONE;
      end
    end
  end

endmodule

// File: tb/tb_cpu_loader_ctrl_6502.sv
// Randomized bench for cpu_loader_ctrl_6502: RAM model with fault injection,
// expected-write scoreboard and per-load outcome model.
module tb_cpu_loader_ctrl_6502;
  localparam int S         = 4;
  localparam int RAM_DEPTH = 4102;

  logic        clk_i = 1'b0, reset_i = 1'b0;
  logic        start_i = 1'b0, verify_i = 1'b0, abort_i = 1'b0, s_valid_i = 1'b0;
  logic [15:0] start_addr_i = '0, length_i = '0;
  logic [7:0]  s_data_i = '0;
  logic        s_ready_o, ram_we_o, cpu_reset_o, cpu_pause_o, busy_o, done_o;
  logic [15:0] ram_addr_o;
  logic [7:0]  ram_din_o, ram_dout_i;
  logic [1:0]  err_code_o;

  int          n_cmp = 0, n_bad = 0;
  logic [7:0]  mem [RAM_DEPTH];
  logic [7:0]  rd_q = '0;
  logic [15:0] rd_addr_q = '0;
  logic        rd_we_q = 1'b0;
  logic        flip_arm = 1'b0;
  logic [15:0] flip_addr = '0;
  logic [23:0] exp_wr[$];
  logic [7:0]  src[$];

  always #5 clk_i = ~clk_i;

  cpu_loader_ctrl_6502 dut (
    .clk_i(clk_i), .reset_i(reset_i), .start_i(start_i), .start_addr_i(start_addr_i),
    .length_i(length_i), .verify_i(verify_i), .abort_i(abort_i), .s_data_i(s_data_i),
    .s_valid_i(s_valid_i), .s_ready_o(s_ready_o), .ram_addr_o(ram_addr_o),
    .ram_we_o(ram_we_o), .ram_din_o(ram_din_o), .ram_dout_i(ram_dout_i),
    .cpu_reset_o(cpu_reset_o), .cpu_pause_o(cpu_pause_o), .busy_o(busy_o),
    .done_o(done_o), .err_code_o(err_code_o)
  );

  // RAM port A: synchronous write, 1-cycle read; optional bit flip on one read address
  always @(posedge clk_i) begin
    if (ram_we_o && ram_addr_o < 16'(RAM_DEPTH)) mem[ram_addr_o] <= ram_din_o;
    rd_q      <= (ram_addr_o < 16'(RAM_DEPTH)) ? mem[ram_addr_o] : 8'h00;
    rd_addr_q <= ram_addr_o;
    rd_we_q   <= ram_we_o;
  end
  assign ram_dout_i = rd_q ^ ((flip_arm && !rd_we_q && rd_addr_q == flip_addr) ? 8'h01 : 8'h00);

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk_i);
    #1;
  endtask

  always @(negedge clk_i) begin
    if (reset_i) begin
      if (ram_we_o) begin
        check_val("gap_write", s_valid_i, 1);
        if (exp_wr.size() == 0) check_val("extra_write", ram_we_o, 0);
        else check_val("write_addr_data", {ram_addr_o, ram_din_o}, exp_wr.pop_front());
      end
      if (!busy_o) check_val("idle_port", {ram_addr_o, ram_we_o}, 0);
    end
  end

  task automatic run_op(input logic [15:0] addr, input logic [15:0] len, input bit ver,
                        input int gap, input int abort_at, input bit flip);
    int idx, k, first_wr, wr_n, rel, n_exp;
    bit rb, ab, v, got_done;
    logic prev_rst, prev_pause;
    logic [1:0] exp_err;
    idx = 0; k = 0; first_wr = -1; wr_n = 0; rel = 0; got_done = 1'b0;
    rb = ({1'b0, addr} + {1'b0, len}) > 17'(RAM_DEPTH);
    ab = !rb && abort_at >= 1 && abort_at < int'(len);
    n_exp = rb ? 0 : (ab ? abort_at : int'(len));
    exp_err = rb ? 2'd1 : (ab ? 2'd3 : ((ver && flip && len >= 16'd2) ? 2'd2 : 2'd0));
    for (int i = 0; i < n_exp; i++) exp_wr.push_back({addr + 16'(i), src[i]});
    flip_addr = addr + 16'd1;
    flip_arm  = flip;
    tick;
    prev_rst = cpu_reset_o; prev_pause = cpu_pause_o;
    start_i = 1'b1; start_addr_i = addr; length_i = len; verify_i = ver;
    while (1'b1) begin
      tick; k++;
      start_i = 1'b0; start_addr_i = 16'($urandom); length_i = 16'($urandom);
      case (gap)
        0:       v = 1'b1;
        1:       v = (k % 3 == 0);
        default: v = 1'($urandom_range(0, 1));
      endcase
      s_valid_i = !rb && idx < int'(len) && v;
      s_data_i  = (idx < src.size()) ? src[idx] : 8'($urandom);
      abort_i   = ab && idx == abort_at && s_valid_i;
      @(negedge clk_i);
      if (k == 1) begin
        if (rb) begin
          check_val("range_err", err_code_o, 1);
          check_val("range_cpu", {busy_o, cpu_reset_o, cpu_pause_o}, {1'b0, prev_rst, prev_pause});
          break;
        end
        check_val("start_err_clr", err_code_o, 0);
        check_val("halt_hold", {busy_o, cpu_reset_o, cpu_pause_o}, 3'b111);
      end
      if (ram_we_o) begin
        wr_n++;
        if (first_wr < 0) first_wr = k;
      end
      if (abort_i) break;
      if (s_valid_i && s_ready_o) idx++;
      if (idx >= int'(len)) break;
      if (k > 3000) begin
        check_val("stream_timeout", idx, len);
        break;
      end
    end
    tick;
    s_valid_i = 1'b0; abort_i = 1'b0;
    for (int c = 0; c < 4 * S + 2 * int'(len) + 40; c++) begin
      @(negedge clk_i);
      if (done_o) begin
        got_done = 1'b1;
        check_val("release_len", rel, S);
        check_val("done_cpu", {cpu_reset_o, cpu_pause_o, err_code_o}, 0);
        break;
      end
      if (cpu_reset_o && !cpu_pause_o) rel++;
      else rel = 0;
      tick;
    end
    if (exp_err == 2'd0) begin
      check_val("done_seen", got_done, 1);
      tick;
      @(negedge clk_i);
      check_val("after_done", {done_o, busy_o, cpu_reset_o}, 0);
    end else begin
      check_val("done_absent", got_done, 0);
      @(negedge clk_i);
      check_val("err_code", err_code_o, exp_err);
      check_val("err_cpu", {busy_o, cpu_reset_o, cpu_pause_o},
                rb ? {1'b0, prev_rst, prev_pause} : 3'b011);
    end
    if (!rb) check_val("write_count", wr_n, n_exp);
    if (gap == 0 && !rb && len != 16'd0) check_val("first_wr_lat", first_wr, S + 1);
    check_val("missing_writes", exp_wr.size(), 0);
    exp_wr.delete();
    flip_arm = 1'b0;
  endtask

  initial begin
    logic [15:0] a, l;
    bit ver, fl;
    int g, ab, idx, k;

    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    check_val("rst_cpu", {cpu_reset_o, cpu_pause_o}, 2'b11);
    check_val("rst_outs", {s_ready_o, ram_we_o, ram_addr_o, ram_din_o, busy_o, done_o, err_code_o}, 0);
    tick; reset_i = 1'b1;
    tick;
    @(negedge clk_i);
    check_val("idle_cpu_run", {cpu_reset_o, cpu_pause_o}, 0);

    src = {8'hA9, 8'h01, 8'h8D, 8'h00};
    run_op(16'h0200, 16'd4, 1'b1, 0, -1, 1'b0);
    for (int i = 0; i < 4; i++) check_val("ram_content", mem[16'h0200 + i], src[i]);

    src = {8'h11, 8'h22, 8'h33};
    run_op(16'h0400, 16'd3, 1'b0, 1, -1, 1'b0);

    src = {8'h5A};
    run_op(16'h1000, 16'd7, 1'b0, 0, -1, 1'b0);

    src.delete();
    for (int i = 0; i < 5; i++) src.push_back(8'($urandom));
    run_op(16'h0800, 16'd5, 1'b1, 0, -1, 1'b1);

    src = {8'hDE, 8'hAD, 8'hBE, 8'hEF};
    run_op(16'h0300, 16'd4, 1'b0, 0, 1, 1'b0);
    src.delete();
    run_op(16'h0310, 16'd0, 1'b1, 0, -1, 1'b0);

    for (int t = 0; t < 12; t++) begin
      l   = 16'($urandom_range(0, 10));
      a   = ($urandom_range(0, 3) == 0) ? 16'(RAM_DEPTH - $urandom_range(0, 8))
                                        : 16'($urandom_range(0, 4000));
      ver = 1'($urandom_range(0, 1));
      g   = $urandom_range(0, 2);
      ab  = ($urandom_range(0, 3) == 0 && l >= 16'd2) ? $urandom_range(1, int'(l) - 1) : -1;
      fl  = ver && l >= 16'd2 && $urandom_range(0, 2) == 0;
      src.delete();
      for (int i = 0; i < int'(l); i++) src.push_back(8'($urandom));
      run_op(a, l, ver, g, ab, fl);
    end

    // asynchronous reset in the middle of a load
    src.delete();
    for (int i = 0; i < 8; i++) src.push_back(8'($urandom));
    for (int i = 0; i < 8; i++) exp_wr.push_back({16'h0300 + 16'(i), src[i]});
    tick;
    start_i = 1'b1; start_addr_i = 16'h0300; length_i = 16'd8; verify_i = 1'b0;
    idx = 0; k = 0;
    while (idx < 3 && k < 50) begin
      tick; k++;
      start_i = 1'b0; s_valid_i = 1'b1; s_data_i = src[idx];
      @(negedge clk_i);
      if (s_valid_i && s_ready_o) idx++;
    end
    check_val("mid_load_progress", idx, 3);
    tick;
    reset_i = 1'b0; s_valid_i = 1'b0;
    @(negedge clk_i);
    check_val("midrst_cpu", {cpu_reset_o, cpu_pause_o}, 2'b11);
    check_val("midrst_outs", {busy_o, done_o, ram_we_o, err_code_o, s_ready_o}, 0);
    exp_wr.delete();
    tick; reset_i = 1'b1;
    tick;
    @(negedge clk_i);
    check_val("midrst_idle", {cpu_reset_o, cpu_pause_o, busy_o}, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
